// File: rtl/boot_loader.sv
// Boot loader: fills instruction memory from a little-endian byte stream,
// then holds the processor in reset for HOLD_CYC cycles before releasing it.
module boot_loader #(
  parameter int ADDR_W   = 10,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [2:0] {
    HDR0, HDR1, LOAD, WRITE, HOLD, RUN
  } state_t;

  localparam logic [16:0] DEPTH     = 17'd1 << ADDR_W;
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYC - 1);

  state_t            state_q;
  logic [7:0]        nLow_q;
  logic [15:0]       wordTotal_q;
  logic [15:0]       wordIdx_q;
  logic [1:0]        byteCnt_q;
  logic [23:0]       wordBuf_q;
  logic [7:0]        holdCnt_q;
  logic              inReady_q;
  logic              imemWe_q;
  logic [ADDR_W-1:0] imemAddr_q;
  logic [31:0]       imemWdata_q;
  logic              cpuRst_q;
  logic              done_q;
  logic              ovf_q;

  logic        accept;
  logic [15:0] hdrCount;
  logic        inRange;

  assign accept   = in_valid & inReady_q;
  assign hdrCount = {in_data, nLow_q};
  // Words past the end of imem are still consumed so the stream stays aligned.
  assign inRange  = ({1'b0, wordIdx_q} < DEPTH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HDR0;
      nLow_q      <= '0;
      wordTotal_q <= '0;
      wordIdx_q   <= '0;
      byteCnt_q   <= '0;
      wordBuf_q   <= '0;
      holdCnt_q   <= '0;
      inReady_q   <= 1'b0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= '0;
      imemWdata_q <= '0;
      cpuRst_q    <= 1'b1;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      imemWe_q <= 1'b0;
      case (state_q)
        HDR0: begin
          inReady_q <= 1'b1;
          if (accept) begin
            nLow_q  <= in_data;
            state_q <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            wordTotal_q <= hdrCount;
            ovf_q       <= ({1'b0, hdrCount} > DEPTH);
            wordIdx_q   <= '0;
            byteCnt_q   <= '0;
            if (hdrCount == 16'd0) begin
              state_q   <= HOLD;
              inReady_q <= 1'b0;
              holdCnt_q <= '0;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wordBuf_q <= {in_data, wordBuf_q[23:8]};
            byteCnt_q <= byteCnt_q + 2'd1;
            if (byteCnt_q == 2'd3) begin
              state_q   <= WRITE;
              inReady_q <= 1'b0;
              if (inRange) begin
                imemWe_q    <= 1'b1;
                imemAddr_q  <= wordIdx_q[ADDR_W-1:0];
                imemWdata_q <= {in_data, wordBuf_q};
              end
            end
          end
        end
        WRITE: begin
          wordIdx_q <= wordIdx_q + 16'd1;
          if (wordIdx_q + 16'd1 == wordTotal_q) begin
            state_q   <= HOLD;
            holdCnt_q <= '0;
          end else begin
            state_q   <= LOAD;
            inReady_q <= 1'b1;
          end
        end
        HOLD: begin
          if (holdCnt_q == HOLD_LAST) begin
            state_q  <= RUN;
            cpuRst_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            holdCnt_q <= holdCnt_q + 8'd1;
          end
        end
        RUN: begin
          inReady_q <= 1'b0;
        end
        default: state_q <= HDR0;
      endcase
    end
  end

  assign in_ready   = inReady_q;
  assign imem_we    = imemWe_q;
  assign imem_addr  = imemAddr_q;
  assign imem_wdata = imemWdata_q;
  assign cpu_rst    = cpuRst_q;
  assign done       = done_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: streams byte sequences and compares imem writes,
// overflow and reset-release timing against a stream-level reference model.
module tb_boot_loader;

  localparam int AW    = 2;
  localparam int HOLD  = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          ovf;

  boot_loader #(.ADDR_W(AW), .HOLD_CYC(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .ovf        (ovf)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          at;
  } wr_t;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  fallCyc = -1;
  int  ovfCyc = -1;
  int  expFall = -1;
  int  expOvf = -1;
  wr_t gotWr[$];
  wr_t expWr[$];

  always #5 clk = ~clk;

  // Edge counter; a value read between edges names the most recent rising edge.
  always @(posedge clk) cyc++;

  // Observe outputs mid-cycle and log write pulses and first rise/fall events.
  always @(negedge clk) begin
    if (imem_we) gotWr.push_back('{int'(imem_addr), imem_wdata, cyc});
    if (cpu_rst === 1'b0 && fallCyc < 0) fallCyc = cyc;
    if (ovf === 1'b1 && ovfCyc < 0) ovfCyc = cyc;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset(input int n, input string tag);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    gotWr.delete();
    fallCyc = -1;
    ovfCyc = -1;
    checkOutput({tag, "_rst_in_ready"}, 64'(in_ready), 64'd0);
    checkOutput({tag, "_rst_imem_we"}, 64'(imem_we), 64'd0);
    checkOutput({tag, "_rst_imem_addr"}, 64'(imem_addr), 64'd0);
    checkOutput({tag, "_rst_imem_wdata"}, 64'(imem_wdata), 64'd0);
    checkOutput({tag, "_rst_cpu_rst"}, 64'(cpu_rst), 64'd1);
    checkOutput({tag, "_rst_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_rst_ovf"}, 64'(ovf), 64'd0);
    rst = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap, output int at);
    int waited;
    bit acc;
    waited = 0;
    if (gap > 0) in_valid = 1'b0;
    repeat (gap) begin
      in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_data = b;
    in_valid = 1'b1;
    forever begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 50) begin
        checkOutput("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    at = cyc;
  endtask

  // Drives a whole stream and derives the expected writes, ovf and release timing from it.
  task automatic applyStimulus(input logic [7:0] s[$], input int gapMode);
    int at[$];
    int a, gap, n, base;
    for (int i = 0; i < s.size(); i++) begin
      gap = 0;
      if (gapMode != 0) begin
        gap = $urandom_range(0, 2);
        if (i >= 2 && ((i - 2) % 4) == 2) gap = 5;
      end
      sendByte(s[i], gap, a);
      at.push_back(a);
    end
    in_valid = 1'b0;
    n = int'(s[0]) + 256 * int'(s[1]);
    expWr.delete();
    for (int w = 0; w < n; w++) begin
      base = 2 + 4 * w;
      if (w < DEPTH)
        expWr.push_back('{w, {s[base+3], s[base+2], s[base+1], s[base]}, at[base+3]});
    end
    expFall = (n == 0) ? at[1] + HOLD : at[2 + 4 * n - 1] + HOLD + 1;
    expOvf  = (n > DEPTH) ? at[1] : -1;
  endtask

  task automatic verifyLoad(input string tag);
    int t;
    int m;
    t = 0;
    while (fallCyc < 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_release_cycle"}, 64'(fallCyc), 64'(expFall));
    checkOutput({tag, "_write_count"}, 64'(gotWr.size()), 64'(expWr.size()));
    m = (gotWr.size() < expWr.size()) ? gotWr.size() : expWr.size();
    for (int i = 0; i < m; i++) begin
      checkOutput($sformatf("%s_w%0d_addr", tag, i), 64'(gotWr[i].addr), 64'(expWr[i].addr));
      checkOutput($sformatf("%s_w%0d_data", tag, i), 64'(gotWr[i].data), 64'(expWr[i].data));
      checkOutput($sformatf("%s_w%0d_cycle", tag, i), 64'(gotWr[i].at), 64'(expWr[i].at));
    end
    checkOutput({tag, "_ovf_cycle"}, 64'(ovfCyc), 64'(expOvf));
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd0);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] basic[$];
    int a, n, prevWr;

    basic = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    // Basic load, continuous valid.
    doReset(3, "basic");
    applyStimulus(basic, 0);
    verifyLoad("basic");
    checkOutput("basic_addr_hold", 64'(imem_addr), 64'd1);
    checkOutput("basic_wdata_hold", 64'(imem_wdata), 64'hDEADBEEF);

    // Same stream with gaps, including a 5-cycle gap mid-word.
    doReset(2, "gaps");
    applyStimulus(basic, 1);
    verifyLoad("gaps");

    // Zero word count.
    doReset(2, "zero");
    s = '{8'h00, 8'h00};
    applyStimulus(s, 0);
    verifyLoad("zero");

    // Overflow: 5 words into a 4-word memory.
    doReset(2, "ovf");
    s = '{8'h05, 8'h00};
    repeat (20) s.push_back(8'($urandom));
    applyStimulus(s, 1);
    verifyLoad("ovf");
    checkOutput("ovf_addr_no_wrap", 64'(imem_addr), 64'd3);
    checkOutput("ovf_sticky", 64'(ovf), 64'd1);

    // Reset after two bytes of the first word, then a fresh stream.
    doReset(2, "midrst");
    sendByte(8'h02, 0, a);
    sendByte(8'h00, 0, a);
    sendByte(8'h78, 0, a);
    sendByte(8'h56, 0, a);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_cpu_rst_held", 64'(fallCyc), -64'sd1);
    checkOutput("midrst_no_write", 64'(gotWr.size()), 64'd0);
    doReset(1, "midrst2");
    s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(s, 0);
    verifyLoad("midrst");

    // Input while running must be ignored.
    prevWr = gotWr.size();
    for (int i = 0; i < 20; i++) begin
      in_data = 8'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("run_in_ready_%0d", i), 64'(in_ready), 64'd0);
      checkOutput($sformatf("run_imem_we_%0d", i), 64'(imem_we), 64'd0);
      checkOutput($sformatf("run_cpu_rst_%0d", i), 64'(cpu_rst), 64'd0);
    end
    in_valid = 1'b0;
    checkOutput("run_no_new_writes", 64'(gotWr.size()), 64'(prevWr));
    checkOutput("run_done", 64'(done), 64'd1);

    // Randomized loads of varying length and gap pattern.
    for (int r = 0; r < 4; r++) begin
      doReset(2, $sformatf("rand%0d", r));
      n = $urandom_range(0, 6);
      s.delete();
      s.push_back(8'(n));
      s.push_back(8'h00);
      repeat (4 * n) s.push_back(8'($urandom));
      applyStimulus(s, $urandom_range(0, 1));
      verifyLoad($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule
